// File: rtl/i2c_arbiter_pkg.sv
// i2c_arbiter_pkg: shared types for the I2C transfer arbiter.
//   i2c_arb_state_t : arbiter FSM state (IDLE, START, WAIT_DONE)
//   i2c_request_t   : one single-register transfer {direction, slave, register, data}
package i2c_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, START, WAIT_DONE} i2c_arb_state_t;
   typedef struct packed {
      logic       direction;
      logic [7:0] slave_address;
      logic [7:0] register_address;
      logic [7:0] data;
   } i2c_request_t;
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: combinational round-robin winner search.
//   request     in  N        pending requests
//   last_grant  in  log2(N)  previous owner, searched last
//   grant       out N        one-hot winner (zero when nothing is pending)
//   grant_index out log2(N)  index of the winner
module rr_priority_select #(
   parameter int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] request,
   input  logic [W-1:0] last_grant,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_index
);
   logic [W-1:0] k;
   // Walk from the farthest candidate to the nearest so the nearest pending
   // requester after last_grant overwrites any earlier hit.
   always_comb begin
      grant = '0;
      grant_index = '0;
      k = '0;
      for (int i = N; i >= 1; i--) begin
         k = W'((int'(last_grant) + i) % N);
         if (request[k]) begin
            grant = '0;
            grant[k] = 1'b1;
            grant_index = k;
         end
      end
   end
endmodule

// File: rtl/i2c_transfer_arbiter.sv
// i2c_transfer_arbiter: round-robin sharing of one I2C master engine among N requesters.
//   clock, reset                  system clock, synchronous active-low reset
//   req_valid/req_ready           per-requester handshake (ready is combinational in IDLE)
//   req_direction/_slave_address/
//   req_register_address/req_data per-requester transfer fields, 8 bits packed per requester
//   req_done/req_error            one-cycle completion / timeout pulse to the owner
//   start, direction, slave_address,
//   register_address, data        engine start pulse and latched transfer fields
//   done                          engine completion pulse
//   busy, grant_id                not-IDLE flag, current or last owner
// Optional watchdog: define I2C_ARBITER_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYCLES cycles in WAIT_DONE.
module i2c_transfer_arbiter
   import i2c_arbiter_pkg::*;
#(
   parameter int N_REQUESTERS = 4,
   parameter int TIMEOUT_CYCLES = 100000,
   localparam int W = $clog2(N_REQUESTERS)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_REQUESTERS-1:0]   req_valid,
   output logic [N_REQUESTERS-1:0]   req_ready,
   input  logic [N_REQUESTERS-1:0]   req_direction,
   input  logic [8*N_REQUESTERS-1:0] req_slave_address,
   input  logic [8*N_REQUESTERS-1:0] req_register_address,
   input  logic [8*N_REQUESTERS-1:0] req_data,
   output logic [N_REQUESTERS-1:0]   req_done,
   output logic [N_REQUESTERS-1:0]   req_error,
   output logic                      start,
   output logic                      direction,
   output logic [7:0]                slave_address,
   output logic [7:0]                register_address,
   output logic [7:0]                data,
   input  logic                      done,
   output logic                      busy,
   output logic [W-1:0]              grant_id
);
   i2c_arb_state_t state, next_state;
   i2c_request_t xfer, pick;
   logic [N_REQUESTERS-1:0] win, owner;
   logic [W-1:0] win_index, last_grant;
   logic accept, finish, timeout;

   rr_priority_select #(.N(N_REQUESTERS)) u_select (
      .request(req_valid),
      .last_grant(last_grant),
      .grant(win),
      .grant_index(win_index)
   );

   assign pick = {req_direction[win_index], req_slave_address[8*win_index +: 8],
                  req_register_address[8*win_index +: 8], req_data[8*win_index +: 8]};
   assign owner = {{(N_REQUESTERS-1){1'b0}}, 1'b1} << grant_id;
   assign accept = state == IDLE && |req_valid;
   assign finish = state == WAIT_DONE && (done || timeout);
   assign {direction, slave_address, register_address, data} = xfer;

`ifdef I2C_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] count;
   // Held at zero outside WAIT_DONE, so it reads 0 on the first WAIT_DONE cycle;
   // firing at TIMEOUT_CYCLES-1 puts the pulse TIMEOUT_CYCLES cycles after entry.
   always_ff @(posedge clock) count <= (!reset || state != WAIT_DONE) ? '0 : count + 1'b1;
   assign timeout = state == WAIT_DONE && count == CW'(TIMEOUT_CYCLES - 1);
`else
   // Watchdog compiled out: WAIT_DONE waits for done indefinitely.
   assign timeout = TIMEOUT_CYCLES < 0;
`endif

   always_ff @(posedge clock) state <= !reset ? IDLE : next_state;

   always_comb begin
      next_state = state == IDLE  ? (accept ? START : IDLE) :
                   state == START ? WAIT_DONE :
                   finish         ? IDLE : WAIT_DONE;
   end

   always_comb begin
      start = state == START;
      busy = state != IDLE;
      req_ready = state == IDLE ? win : '0;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         xfer <= '0;
         grant_id <= '0;
         last_grant <= W'(N_REQUESTERS - 1);
         req_done <= '0;
         req_error <= '0;
      end else begin
         req_done <= finish ? owner : '0;
         // A done coinciding with the timeout wins: completion without error.
         req_error <= (finish && !done) ? owner : '0;
         if (accept) begin
            xfer <= pick;
            grant_id <= win_index;
         end
         if (finish) last_grant <= grant_id;
      end
   end
endmodule

// File: tb/tb_i2c_transfer_arbiter.sv
// tb_i2c_transfer_arbiter: scoreboard bench for the I2C transfer arbiter.
module tb_i2c_transfer_arbiter;
   localparam int N = 4;
`ifdef I2C_ARBITER_TIMEOUT_EN
   localparam int TO = 50;
`else
   localparam int TO = 100000;
`endif
   typedef struct {
      logic [1:0] id;
      logic       dir;
      logic [7:0] sa;
      logic [7:0] ra;
      logic [7:0] dt;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic [N-1:0] req_valid = '0, req_direction = '0;
   logic [8*N-1:0] req_slave_address = '0, req_register_address = '0, req_data = '0;
   logic [N-1:0] req_ready, req_done, req_error;
   logic start, direction, busy;
   logic done = 1'b0;
   logic [7:0] slave_address, register_address, data;
   logic [1:0] grant_id;

   exp_t sbq[$];
   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   i2c_transfer_arbiter #(.N_REQUESTERS(N), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_direction(req_direction),
      .req_slave_address(req_slave_address), .req_register_address(req_register_address),
      .req_data(req_data), .req_done(req_done), .req_error(req_error),
      .start(start), .direction(direction), .slave_address(slave_address),
      .register_address(register_address), .data(data), .done(done),
      .busy(busy), .grant_id(grant_id)
   );

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic set_req(input int i, input logic dir, input logic [7:0] sa, input logic [7:0] ra, input logic [7:0] dt);
      req_valid[i] = 1'b1;
      req_direction[i] = dir;
      req_slave_address[8*i +: 8] = sa;
      req_register_address[8*i +: 8] = ra;
      req_data[8*i +: 8] = dt;
   endtask

   task automatic push(input int i);
      exp_t e;
      e.id = 2'(i);
      e.dir = req_direction[i];
      e.sa = req_slave_address[8*i +: 8];
      e.ra = req_register_address[8*i +: 8];
      e.dt = req_data[8*i +: 8];
      sbq.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req_valid = '0;
      done = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic wait_start(output bit seen);
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         tick();
         seen = start;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req_valid = '0;
      tick();
      tick();
      vectors++;
      if ({start, busy, req_done, req_error, req_ready} !== '0)
         $display("FAIL reset_ctrl: got %b want 0", {start, busy, req_done, req_error, req_ready});
      vectors++;
      if ({direction, slave_address, register_address, data, grant_id} !== '0)
         $display("FAIL reset_fields: got %h want 0", {direction, slave_address, register_address, data, grant_id});
      if ({start, busy, req_done, req_error, req_ready} !== '0 || {direction, slave_address, register_address, data, grant_id} !== '0)
         miscompares++;
      reset = 1'b1;
   endtask

   task automatic test_single();
      exp_t e;
      do_reset();
      set_req(2, 1'b0, 8'h50, 8'h10, 8'hA5);
      push(2);
      #1;
      vectors++;
      if (req_ready !== 4'b0100) begin
         miscompares++;
         $display("FAIL single_ready: got %b want 0100", req_ready);
      end
      tick();
      req_valid = '0;
      e = sbq.pop_front();
      vectors++;
      if (start !== 1'b1) begin
         miscompares++;
         $display("FAIL single_start: got %b want 1", start);
      end
      vectors++;
      if ({grant_id, direction, slave_address, register_address, data} !== {e.id, e.dir, e.sa, e.ra, e.dt}) begin
         miscompares++;
         $display("FAIL single_fields: got %h want %h", {grant_id, direction, slave_address, register_address, data}, {e.id, e.dir, e.sa, e.ra, e.dt});
      end
      tick();
      vectors++;
      if ({start, busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL single_start_width: got %b want 01", {start, busy});
      end
      repeat (19) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      vectors++;
      if ({req_done, busy} !== 5'b0100_0) begin
         miscompares++;
         $display("FAIL single_done: got %b want 01000", {req_done, busy});
      end
      tick();
      vectors++;
      if (req_done !== 4'b0000) begin
         miscompares++;
         $display("FAIL single_done_width: got %b want 0000", req_done);
      end
   endtask

   task automatic test_round_robin();
      exp_t e;
      bit seen;
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, i[0], 8'(32'h20 + i), 8'(32'h30 + i), 8'(32'h40 + i));
      for (int k = 0; k < 5; k++) push(k % N);
      for (int k = 0; k < 5; k++) begin
         wait_start(seen);
         vectors++;
         if (!seen) begin
            miscompares++;
            $display("FAIL rr_start_timeout: got no start want start for transfer %0d", k);
         end
         e = sbq.pop_front();
         vectors++;
         if ({grant_id, direction, slave_address, register_address, data} !== {e.id, e.dir, e.sa, e.ra, e.dt}) begin
            miscompares++;
            $display("FAIL rr_grant_%0d: got %h want %h", k, {grant_id, direction, slave_address, register_address, data}, {e.id, e.dir, e.sa, e.ra, e.dt});
         end
         tick();
         vectors++;
         if (start !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_start_width_%0d: got %b want 0", k, start);
         end
         done = 1'b1;
         #1;
         vectors++;
         if (req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL rr_ready_during_done_%0d: got %b want 0000", k, req_ready);
         end
         tick();
         done = 1'b0;
         vectors++;
         if (req_done !== 4'(1 << e.id)) begin
            miscompares++;
            $display("FAIL rr_done_%0d: got %b want %b", k, req_done, 4'(1 << e.id));
         end
      end
      req_valid = '0;
   endtask

   task automatic test_ignore_done();
      do_reset();
      done = 1'b1;
      repeat (3) tick();
      vectors++;
      if ({busy, req_done} !== 5'b0) begin
         miscompares++;
         $display("FAIL idle_done_ignored: got %b want 00000", {busy, req_done});
      end
      done = 1'b0;
      set_req(1, 1'b1, 8'h11, 8'h22, 8'h33);
      tick();
      req_valid = '0;
      vectors++;
      if (start !== 1'b1) begin
         miscompares++;
         $display("FAIL ignore_start: got %b want 1", start);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      vectors++;
      if ({start, busy, req_done} !== 6'b01_0000) begin
         miscompares++;
         $display("FAIL start_done_ignored: got %b want 010000", {start, busy, req_done});
      end
      repeat (3) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      vectors++;
      if (req_done !== 4'b0010) begin
         miscompares++;
         $display("FAIL ignore_final_done: got %b want 0010", req_done);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      do_reset();
      set_req(1, 1'b0, 8'h01, 8'h02, 8'h03);
      tick();
      req_valid = '0;
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      set_req(3, 1'b1, 8'h77, 8'h66, 8'h55);
      tick();
      req_valid = '0;
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      vectors++;
      if ({start, busy, req_done, req_error, req_ready, direction, slave_address, register_address, data, grant_id} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_outputs: got %h want 0", {start, busy, req_done, req_error, req_ready, direction, slave_address, register_address, data, grant_id});
      end
      bad = 0;
      repeat (3) begin
         tick();
         if (req_done !== 4'b0000) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL mid_reset_no_done: got %0d pulses want 0", bad);
      end
      set_req(0, 1'b0, 8'h0A, 8'h0B, 8'h0C);
      set_req(2, 1'b0, 8'h2A, 8'h2B, 8'h2C);
      #1;
      vectors++;
      if (req_ready !== 4'b0001) begin
         miscompares++;
         $display("FAIL mid_reset_next_grant: got %b want 0001", req_ready);
      end
      tick();
      req_valid = '0;
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   task automatic test_watchdog();
      int hit;
      logic [N-1:0] err;
      do_reset();
      set_req(0, 1'b1, 8'h42, 8'h43, 8'h44);
      tick();
      req_valid = '0;
      tick();
`ifdef I2C_ARBITER_TIMEOUT_EN
      hit = 0;
      err = '0;
      for (int c = 1; c <= 60 && hit == 0; c++) begin
         tick();
         if (req_done !== 4'b0000) begin
            hit = c;
            err = req_error;
         end
      end
      vectors++;
      if (hit !== 50) begin
         miscompares++;
         $display("FAIL watchdog_delay: got %0d want 50", hit);
      end
      vectors++;
      if (err !== 4'b0001) begin
         miscompares++;
         $display("FAIL watchdog_error: got %b want 0001", err);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL watchdog_idle: got %b want 0", busy);
      end
`else
      hit = 0;
      for (int c = 0; c < 1000; c++) begin
         tick();
         if (busy !== 1'b1 || req_error !== 4'b0000 || req_done !== 4'b0000) hit++;
      end
      vectors++;
      if (hit !== 0) begin
         miscompares++;
         $display("FAIL no_watchdog_hold: got %0d bad cycles want 0", hit);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      err = req_error;
      vectors++;
      if ({req_done, err} !== 8'b0001_0000) begin
         miscompares++;
         $display("FAIL no_watchdog_done: got %b want 00010000", {req_done, err});
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_ignore_done();
      test_reset_mid();
      test_watchdog();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
